// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the byte_unstriping_n lane recombiner.
package byte_unstriping_pkg;

  localparam int unsigned LANES_DEF   = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned SKEW_TO_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/byte_unstriping_n_lane_fifo.sv
// lane_fifo: per-lane deskew FIFO. Registered storage, no bypass path.
// A push onto a full FIFO succeeds only when a pop happens on the same edge;
// otherwise the word is dropped and overflow pulses for one cycle.
module lane_fifo
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & (~full | do_pop) & ~flush;
  assign overflow = push & full & ~do_pop & ~flush;
  assign dout     = mem_q[rd_q];
  assign count    = cnt_q;

  // Pointer and occupancy next-state; flush empties the FIFO
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Occupancy state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/byte_unstriping_n.sv
// byte_unstriping_n: recombines LANES striped lanes into one word stream in
// round-robin lane order, with per-lane deskew FIFOs and a skew timeout.
// Build macro BYTE_UNSTRIPING_STATS_EN adds the 16-bit word_count output.
module byte_unstriping_n
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned SKEW_TO = SKEW_TO_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] lane_in,
  input  logic [LANES-1:0]        valid_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic [LANES-1:0]        err_overflow,
  output logic                    err_skew,
  output logic                    busy
`ifdef BYTE_UNSTRIPING_STATS_EN
  ,
  output logic [15:0]             word_count
`endif
);

  localparam int unsigned PW = $clog2(LANES);
  localparam int unsigned CW = $clog2(SKEW_TO) + 1;
  localparam int unsigned FW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(SKEW_TO);
  localparam logic [FW-1:0] CNT_ONE = FW'(1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     tcnt_q, tcnt_d, tcnt_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LANES-1:0]  ovf_q, ovf_d;
  logic              skew_q, skew_d;

  logic              flush, pop_now;
  logic [LANES-1:0]  push, pop, empty, empty_after, ovf_pulse;
  // Drop reporting comes from the overflow pulse, so full is not needed here
  logic [LANES-1:0]  full_unused;
  logic [DATA_W-1:0] f_dout [LANES];
  logic [FW-1:0]     f_cnt  [LANES];

  assign flush    = (state_q == ERROR);
  assign push     = flush ? '0 : valid_in;
  assign pop_now  = (state_q == RUN) && !empty[ptr_q];
  assign tcnt_inc = (tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + 1'b1;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .flush    (flush),
      .push     (push[k]),
      .pop      (pop[k]),
      .din      (lane_in[k*DATA_W +: DATA_W]),
      .dout     (f_dout[k]),
      .empty    (empty[k]),
      .full     (full_unused[k]),
      .overflow (ovf_pulse[k]),
      .count    (f_cnt[k])
    );
  end

  // Pop strobe for the lane addressed by the round-robin pointer
  always_comb begin
    pop = '0;
    if (pop_now) pop[ptr_q] = 1'b1;
  end

  // Lane emptiness after this edge; only meaningful when no pushes arrive
  always_comb begin
    empty_after = '0;
    for (int unsigned k = 0; k < LANES; k++)
      empty_after[k] = empty[k] | (pop[k] & (f_cnt[k] == CNT_ONE));
  end

  // FSM next state, pointer, timeout counter and output next values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    skew_d  = skew_q;
    ovf_d   = ovf_q | ovf_pulse;
    unique case (state_q)
      IDLE: begin
        ptr_d  = '0;
        tcnt_d = '0;
        if (|valid_in) state_d = ALIGN;
      end
      ALIGN: begin
        if (empty == '0) begin
          state_d = RUN;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TO_MAX) begin
            state_d = ERROR;
            skew_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (pop_now) begin
          data_d  = f_dout[ptr_q];
          valid_d = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_inc;
        end
        // End of stream takes priority over a stall timeout on the same edge
        if (ptr_d == '0 && empty_after == '1 && valid_in == '0) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (!pop_now && tcnt_inc == TO_MAX) begin
          state_d = ERROR;
          skew_d  = 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
      skew_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      skew_q  <= skew_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign err_overflow = ovf_q;
  assign err_skew     = skew_q;
  assign busy         = (state_q == ALIGN) || (state_q == RUN);

`ifdef BYTE_UNSTRIPING_STATS_EN
  logic [15:0] wcnt_q;

  // Emitted-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wcnt_q <= '0;
    else        wcnt_q <= wcnt_q + 16'(valid_d);
  end

  assign word_count = wcnt_q;
`endif

endmodule

// File: doc/byte_unstriping_n.md
Name: byte_unstriping_n

Overview:
- Parametrised successor to the two-lane byte unstriper. Recombines LANES parallel striped lanes into one output word stream in round-robin order: lane 0, 1, ..., LANES-1, then lane 0 again.
- Adds a per-lane deskew FIFO, an IDLE/ALIGN/RUN/ERROR state machine with a skew timeout, and sticky per-lane overflow flags.
- Sits at the receive side of the lane-striped link, after the per-lane receivers and before the packet parser.

Parameters:
- LANES, 4, number of lanes; power of 2, range 2..8.
- DATA_W, 32, width of each lane word and of data_out.
- DEPTH, 4, entries per lane deskew FIFO; power of 2, minimum 2.
- SKEW_TO, 8, maximum cycles spent waiting on one lane (in ALIGN or on a RUN stall) before entering ERROR.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately.
- lane_in, input, LANES*DATA_W, packed lane words; lane k occupies [k*DATA_W +: DATA_W].
- valid_in, input, LANES, bit k qualifies lane k for the current cycle.
- data_out, output, DATA_W, unstriped word (registered).
- valid_out, output, 1, data_out holds a new word this cycle (registered).
- err_overflow, output, LANES, sticky; a word was dropped on lane k.
- err_skew, output, 1, sticky; the skew timeout expired.
- busy, output, 1, high when the FSM is in ALIGN or RUN.

Behaviour:
- Reset (reset=0, asynchronous): data_out=0, valid_out=0, err_overflow=0, err_skew=0, busy=0. All FIFOs are emptied, the round-robin pointer ptr=0, the timeout counter=0, and state=IDLE. Asserting reset mid-stream discards every buffered word; nothing resumes after release.
- FIFO write: on each edge, for every lane with valid_in[k]=1, the word is pushed into FIFO k.
- FIFO full: if FIFO k is full and no pop of lane k occurs on the same edge, the word is dropped and err_overflow[k] is set. A simultaneous push and pop on a full FIFO succeeds and the count stays at DEPTH.
- Latency: a word pushed at edge t can be popped at edge t+1 at the earliest. There is no bypass path.
- IDLE: goes to ALIGN when any valid_in bit is 1. busy=0.
- ALIGN: waits until every FIFO is non-empty, then goes to RUN. The counter increments on each cycle spent in ALIGN. When the counter reaches SKEW_TO, go to ERROR.
- RUN, pop: if FIFO[ptr] is non-empty, pop it. data_out<=word, valid_out<=1, ptr<=ptr+1 modulo LANES, counter cleared.
- RUN, stall: if FIFO[ptr] is empty, valid_out<=0 and the counter increments. When the counter reaches SKEW_TO, go to ERROR.
- RUN, end of stream: go to IDLE when all of the following hold on the same edge: ptr==0 after the update, all FIFOs are empty after the update, and valid_in==0.
- ERROR: set err_skew, valid_out=0, flush all FIFOs, and ignore inputs. Leave only via reset.
- valid_out is a one-cycle qualifier. data_out holds its last value while valid_out=0.
- Arithmetic: FIFO counts are $clog2(DEPTH)+1 bits wide. ptr is $clog2(LANES) bits and wraps naturally. The counter is $clog2(SKEW_TO)+1 bits and saturates at SKEW_TO.

Optional Feature:
- Macro: BYTE_UNSTRIPING_STATS_EN.
- Defined: adds output port word_count (16 bits). It increments on every edge where valid_out is set, wraps at 16'hFFFF to 0, and is cleared by reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package byte_unstriping_pkg holds:
  - the state encoding: IDLE=2'd0, ALIGN=2'd1, RUN=2'd2, ERROR=2'd3;
  - default constants for LANES, DATA_W, DEPTH and SKEW_TO.
- One sub-module: lane_fifo, a synchronous FIFO of width DATA_W and depth DEPTH.
  - Ports: push, pop, din, dout, empty, full, overflow pulse.
  - Instantiated LANES times with a generate loop.
- The top level contains the FSM, the round-robin pointer, the timeout counter and the output registers.

Test Plan:
- Aligned stream: LANES=4, all lanes valid for 2 cycles with lane k carrying 32'hA0+k in cycle 0 and 32'hB0+k in cycle 1. Expect data_out = A0, A1, A2, A3, B0, B1, B2, B3 on consecutive cycles, the first valid 2 cycles after the first input, then a return to IDLE with busy=0.
- Skewed lanes: lane 3 arrives 3 cycles after lanes 0..2 (3 < SKEW_TO). Expect output order unchanged, no gaps once RUN is entered, and err_skew=0.
- Skew timeout: lanes 0..2 valid, lane 3 never valid. Expect ALIGN for SKEW_TO cycles, then err_skew=1, valid_out stays 0, busy=0 until reset.
- Overflow: DEPTH=4; hold lane 3 silent while lanes 0..2 send 5 consecutive words. Expect err_overflow=4'b0111, with the 5th word on each of lanes 0..2 dropped.
- Mid-stream reset: drop reset for 1 cycle while in RUN with words buffered. Expect all outputs 0 immediately (asynchronous), state IDLE, and none of the stale words emitted after release.
- Stats, built with BYTE_UNSTRIPING_STATS_EN: run 3 aligned rounds with LANES=4. Expect word_count=12; with the counter preloaded to 16'hFFFF, one more output word gives 0.
